// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the accumulator-machine controller: opcodes, FSM states and
// the control-strobe bundle with its bus-safe default value.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LDA = 3'b000,
    OP_STA = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_JMP = 3'b100,
    OP_JZ  = 3'b101,
    OP_LDI = 3'b110,
    OP_HLT = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MRD,
    S_MWR,
    S_ALU,
    S_BR,
    S_HALT,
    S_FAULT
  } ctrl_state_e;

  typedef struct packed {
    logic mem_rd;
    logic mem_wr;
    logic ir_on_adr;
    logic pc_on_adr;
    logic data_on_dbus;
    logic dbus_on_data;
    logic alu_on_dbus;
    logic load_ir;
    logic inc;
    logic clr_pc;
    logic load_pc;
    logic load_ac;
    logic ldimm;
    logic add;
    logic mult;
    logic pass;
    logic halted;
    logic instr_done;
    logic fault;
  } ctrl_out_t;

  // PC drives the address bus and memory data flows inward unless a state says otherwise.
  localparam ctrl_out_t CTRL_DEFAULT = '{pc_on_adr: 1'b1, dbus_on_data: 1'b1, default: 1'b0};

  function automatic logic is_wait_state(ctrl_state_e s);
    return (s == S_FETCH) || (s == S_MRD) || (s == S_MWR);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface cpu_controller_if;

  logic [2:0] op_code;
  logic       zeroflagac;
  logic       mem_ready;

  logic mem_rd, mem_wr;
  logic ir_on_adr, pc_on_adr, data_on_dbus, dbus_on_data, alu_on_dbus;
  logic load_ir, inc, clr_pc, load_pc, load_ac, ldimm, add, mult, pass;
  logic increm, sr, sleft, zero, stcrry, clrcrry, comp;
  logic halted, instr_done, fault;

  modport master (
    input  op_code, zeroflagac, mem_ready,
    output mem_rd, mem_wr,
    output ir_on_adr, pc_on_adr, data_on_dbus, dbus_on_data, alu_on_dbus,
    output load_ir, inc, clr_pc, load_pc, load_ac, ldimm, add, mult, pass,
    output increm, sr, sleft, zero, stcrry, clrcrry, comp,
    output halted, instr_done, fault
  );

  modport slave (
    output op_code, zeroflagac, mem_ready,
    input  mem_rd, mem_wr,
    input  ir_on_adr, pc_on_adr, data_on_dbus, dbus_on_data, alu_on_dbus,
    input  load_ir, inc, clr_pc, load_pc, load_ac, ldimm, add, mult, pass,
    input  increm, sr, sleft, zero, stcrry, clrcrry, comp,
    input  halted, instr_done, fault
  );

endinterface

// File: rtl/ctrl_wait_timer.sv
// Memory-wait watchdog: counts consecutive not-ready cycles of one wait state.
// Only built when CTRL_TIMEOUT_EN is defined.
`ifdef CTRL_TIMEOUT_EN
module ctrl_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  output logic expire_o
);

  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;

  logic [CW-1:0] cnt_q, cnt_d;

  // Any non-waiting cycle precedes entry to a wait state, so it doubles as the clear.
  assign cnt_d    = tick_i ? cnt_q + 1'b1 : '0;
  assign expire_o = tick_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/cpu_controller.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator datapath.
// Define CTRL_TIMEOUT_EN to add the sticky memory-timeout fault.
module cpu_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic              clk,
  input logic              rst_n,
  cpu_controller_if.master bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  ctrl_state_e state_q;
  opcode_e     opcode_q;
  ctrl_out_t   ctrl;
  logic        timeout;

`ifdef CTRL_TIMEOUT_EN
  ctrl_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (is_wait_state(state_q) && !bus.mem_ready),
    .expire_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      opcode_q <= OP_HLT;
    end else begin
      case (state_q)
        S_RESET: state_q <= S_FETCH;
        S_FETCH: begin
          if (bus.mem_ready) state_q <= S_DECODE;
          else if (timeout)  state_q <= S_FAULT;
        end
        S_DECODE: begin
          opcode_q <= opcode_e'(bus.op_code);
          case (bus.op_code)
            OP_LDA:                 state_q <= S_MRD;
            OP_STA:                 state_q <= S_MWR;
            OP_ADD, OP_MUL, OP_LDI: state_q <= S_ALU;
            OP_JMP, OP_JZ:          state_q <= S_BR;
            default:                state_q <= S_HALT;
          endcase
        end
        S_MRD, S_MWR: begin
          if (bus.mem_ready) state_q <= S_FETCH;
          else if (timeout)  state_q <= S_FAULT;
        end
        S_ALU, S_BR: state_q <= S_FETCH;
        default:     state_q <= state_q;
      endcase
    end
  end

  always_comb begin
    // NOTE: start from the default bundle so every field is assigned on every path (no latches).
    ctrl = CTRL_DEFAULT;
    case (state_q)
      // Held low while rst_n is asserted; the PC clear fires in the first cycle after release.
      S_RESET: ctrl.clr_pc = rst_n;
      S_FETCH: begin
        ctrl.mem_rd       = 1'b1;
        ctrl.data_on_dbus = 1'b1;
        ctrl.dbus_on_data = 1'b0;
        ctrl.load_ir      = bus.mem_ready;
        ctrl.inc          = bus.mem_ready;
      end
      S_MRD: begin
        ctrl.ir_on_adr    = 1'b1;
        ctrl.pc_on_adr    = 1'b0;
        ctrl.mem_rd       = 1'b1;
        ctrl.data_on_dbus = 1'b1;
        ctrl.dbus_on_data = 1'b0;
        ctrl.load_ac      = bus.mem_ready;
        ctrl.instr_done   = bus.mem_ready;
      end
      S_MWR: begin
        ctrl.ir_on_adr   = 1'b1;
        ctrl.pc_on_adr   = 1'b0;
        ctrl.mem_wr      = 1'b1;
        ctrl.pass        = 1'b1;
        ctrl.alu_on_dbus = 1'b1;
        ctrl.instr_done  = bus.mem_ready;
      end
      S_ALU: begin
        ctrl.alu_on_dbus = 1'b1;
        ctrl.instr_done  = 1'b1;
        case (opcode_q)
          OP_ADD:  begin ctrl.add  = 1'b1; ctrl.load_ac = 1'b1; end
          OP_MUL:  begin ctrl.mult = 1'b1; ctrl.load_ac = 1'b1; end
          default: begin ctrl.pass = 1'b1; ctrl.ldimm   = 1'b1; end
        endcase
      end
      S_BR: begin
        ctrl.instr_done = 1'b1;
        ctrl.load_pc    = (opcode_q == OP_JMP) ? 1'b1 : bus.zeroflagac;
      end
      S_HALT: ctrl.halted = 1'b1;
`ifdef CTRL_TIMEOUT_EN
      S_FAULT: ctrl.fault = 1'b1;
`endif
      default: ;
    endcase
  end

  assign bus.mem_rd       = ctrl.mem_rd;
  assign bus.mem_wr       = ctrl.mem_wr;
  assign bus.ir_on_adr    = ctrl.ir_on_adr;
  assign bus.pc_on_adr    = ctrl.pc_on_adr;
  assign bus.data_on_dbus = ctrl.data_on_dbus;
  assign bus.dbus_on_data = ctrl.dbus_on_data;
  assign bus.alu_on_dbus  = ctrl.alu_on_dbus;
  assign bus.load_ir      = ctrl.load_ir;
  assign bus.inc          = ctrl.inc;
  assign bus.clr_pc       = ctrl.clr_pc;
  assign bus.load_pc      = ctrl.load_pc;
  assign bus.load_ac      = ctrl.load_ac;
  assign bus.ldimm        = ctrl.ldimm;
  assign bus.add          = ctrl.add;
  assign bus.mult         = ctrl.mult;
  assign bus.pass         = ctrl.pass;
  assign bus.halted       = ctrl.halted;
  assign bus.instr_done   = ctrl.instr_done;
  assign bus.fault        = ctrl.fault;

  // Datapath strobes not used by this instruction set.
  assign bus.increm  = 1'b0;
  assign bus.sr      = 1'b0;
  assign bus.sleft   = 1'b0;
  assign bus.zero    = 1'b0;
  assign bus.stcrry  = 1'b0;
  assign bus.clrcrry = 1'b0;
  assign bus.comp    = 1'b0;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed-vector bench for cpu_controller: per-cycle expected output vectors and
// instruction retire lengths are queued by the stimulus and checked by a monitor.
module tb_cpu_controller;
  import cpu_ctrl_pkg::*;

  typedef logic [25:0] vec_t;
  typedef struct {
    vec_t  v;
    string tag;
  } exp_t;

  localparam vec_t M_RD    = 26'h1 << 0;
  localparam vec_t M_WR    = 26'h1 << 1;
  localparam vec_t M_IRA   = 26'h1 << 2;
  localparam vec_t M_PCA   = 26'h1 << 3;
  localparam vec_t M_DOD   = 26'h1 << 4;
  localparam vec_t M_DBD   = 26'h1 << 5;
  localparam vec_t M_ALU   = 26'h1 << 6;
  localparam vec_t M_LIR   = 26'h1 << 7;
  localparam vec_t M_INC   = 26'h1 << 8;
  localparam vec_t M_CLR   = 26'h1 << 9;
  localparam vec_t M_LPC   = 26'h1 << 10;
  localparam vec_t M_LAC   = 26'h1 << 11;
  localparam vec_t M_LDI   = 26'h1 << 12;
  localparam vec_t M_ADD   = 26'h1 << 13;
  localparam vec_t M_MUL   = 26'h1 << 14;
  localparam vec_t M_PASS  = 26'h1 << 15;
  localparam vec_t M_HALT  = 26'h1 << 16;
  localparam vec_t M_DONE  = 26'h1 << 17;
  localparam vec_t M_FAULT = 26'h1 << 18;

  localparam vec_t IDLE     = M_PCA | M_DBD;
  localparam vec_t RST_CLR  = IDLE | M_CLR;
  localparam vec_t F_WAIT   = M_PCA | M_RD | M_DOD;
  localparam vec_t F_RDY    = F_WAIT | M_LIR | M_INC;
  localparam vec_t DEC      = IDLE;
  localparam vec_t MRD_WAIT = M_IRA | M_RD | M_DOD;
  localparam vec_t MRD_RDY  = MRD_WAIT | M_LAC | M_DONE;
  localparam vec_t MWR_WAIT = M_IRA | M_WR | M_PASS | M_ALU | M_DBD;
  localparam vec_t MWR_RDY  = MWR_WAIT | M_DONE;
  localparam vec_t ALU_ADD  = IDLE | M_ALU | M_ADD | M_LAC | M_DONE;
  localparam vec_t ALU_MUL  = IDLE | M_ALU | M_MUL | M_LAC | M_DONE;
  localparam vec_t ALU_LDI  = IDLE | M_ALU | M_PASS | M_LDI | M_DONE;
  localparam vec_t BR_T     = IDLE | M_LPC | M_DONE;
  localparam vec_t BR_NT    = IDLE | M_DONE;
  localparam vec_t HALT     = IDLE | M_HALT;
  localparam vec_t FAULT    = IDLE | M_FAULT;

  logic clk = 1'b0;
  logic rst_n;

  cpu_controller_if bus_if ();

  cpu_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  int   retire_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t sample();
    return {bus_if.comp, bus_if.clrcrry, bus_if.stcrry, bus_if.zero, bus_if.sleft, bus_if.sr,
            bus_if.increm, bus_if.fault, bus_if.instr_done, bus_if.halted, bus_if.pass,
            bus_if.mult, bus_if.add, bus_if.ldimm, bus_if.load_ac, bus_if.load_pc,
            bus_if.clr_pc, bus_if.inc, bus_if.load_ir, bus_if.alu_on_dbus,
            bus_if.dbus_on_data, bus_if.data_on_dbus, bus_if.pc_on_adr, bus_if.ir_on_adr,
            bus_if.mem_wr, bus_if.mem_rd};
  endfunction

  // One clock cycle of stimulus, driven just after the rising edge, plus its expected outputs.
  task automatic cyc(input logic rst, input logic rdy, input logic [2:0] opc, input logic zf,
                     input vec_t exp, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n             = rst;
    bus_if.mem_ready  = rdy;
    bus_if.op_code    = opc;
    bus_if.zeroflagac = zf;
    e.v   = exp;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic fetch();
    cyc(1'b1, 1'b1, 3'b000, 1'b0, F_RDY, "fetch");
  endtask

  task automatic decode(input opcode_e op);
    cyc(1'b1, 1'b1, op, 1'b0, DEC, "decode");
  endtask

  task automatic restart();
    cyc(1'b0, 1'b1, 3'b000, 1'b0, IDLE, "reset");
    cyc(1'b1, 1'b1, 3'b000, 1'b0, RST_CLR, "rst_exit");
  endtask

  initial begin : monitor
    vec_t act;
    exp_t e;
    int   since;
    logic inv_ok;
    since = 0;
    forever begin
      @(negedge clk);
      act    = sample();
      inv_ok = (bus_if.ir_on_adr ^ bus_if.pc_on_adr) &
               (bus_if.data_on_dbus ^ bus_if.dbus_on_data) &
               !(bus_if.data_on_dbus & bus_if.alu_on_dbus) &
               (!bus_if.mem_rd | bus_if.data_on_dbus);
      check("bus_invariant", {31'd0, inv_ok}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(e.tag, {6'd0, act}, {6'd0, e.v});
      end
      if (!rst_n || bus_if.clr_pc) begin
        since = 0;
      end else begin
        since++;
        if (bus_if.instr_done) begin
          check("retire_pending", {31'd0, retire_q.size() != 0}, 32'd1);
          if (retire_q.size() != 0) check("retire_cycles", since, retire_q.pop_front());
          since = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n             = 1'b0;
    bus_if.mem_ready  = 1'b0;
    bus_if.op_code    = 3'b000;
    bus_if.zeroflagac = 1'b0;

    cyc(1'b0, 1'b0, 3'b000, 1'b0, IDLE, "reset");
    cyc(1'b0, 1'b1, 3'b000, 1'b0, IDLE, "reset");
    cyc(1'b1, 1'b1, 3'b000, 1'b0, RST_CLR, "rst_exit");
    fetch();
    decode(OP_HLT);
    repeat (3) cyc(1'b1, 1'b1, 3'b000, 1'b0, HALT, "halt");

    restart();
    retire_q.push_back(3); fetch(); decode(OP_LDA); cyc(1'b1, 1'b1, 3'b000, 1'b0, MRD_RDY, "lda");
    retire_q.push_back(3); fetch(); decode(OP_ADD); cyc(1'b1, 1'b1, 3'b000, 1'b0, ALU_ADD, "add");
    retire_q.push_back(3); fetch(); decode(OP_STA); cyc(1'b1, 1'b1, 3'b000, 1'b0, MWR_RDY, "sta");
    retire_q.push_back(3); fetch(); decode(OP_MUL); cyc(1'b1, 1'b1, 3'b000, 1'b0, ALU_MUL, "mul");
    retire_q.push_back(3); fetch(); decode(OP_LDI); cyc(1'b1, 1'b1, 3'b000, 1'b0, ALU_LDI, "ldi");
    retire_q.push_back(3); fetch(); decode(OP_JMP); cyc(1'b1, 1'b1, 3'b000, 1'b0, BR_T, "jmp");

    // JZ must follow the flag in the branch cycle, not the one seen during decode.
    retire_q.push_back(3); fetch();
    cyc(1'b1, 1'b1, OP_JZ, 1'b1, DEC, "decode");
    cyc(1'b1, 1'b1, 3'b000, 1'b0, BR_NT, "jz_not_taken");
    retire_q.push_back(3); fetch();
    cyc(1'b1, 1'b1, OP_JZ, 1'b0, DEC, "decode");
    cyc(1'b1, 1'b1, 3'b000, 1'b1, BR_T, "jz_taken");

    retire_q.push_back(9);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, F_WAIT, "fetch_wait");
    fetch(); decode(OP_LDA);
    repeat (5) cyc(1'b1, 1'b0, 3'b000, 1'b0, MRD_WAIT, "lda_wait");
    cyc(1'b1, 1'b1, 3'b000, 1'b0, MRD_RDY, "lda_ready");

    fetch(); decode(OP_STA);
    repeat (2) cyc(1'b1, 1'b0, 3'b000, 1'b0, MWR_WAIT, "sta_wait");
    cyc(1'b0, 1'b0, 3'b000, 1'b0, IDLE, "sta_abort");
    cyc(1'b0, 1'b1, 3'b000, 1'b0, IDLE, "reset");
    cyc(1'b1, 1'b1, 3'b000, 1'b0, RST_CLR, "rst_exit");
    retire_q.push_back(3); fetch(); decode(OP_ADD); cyc(1'b1, 1'b1, 3'b000, 1'b0, ALU_ADD, "add");
    fetch(); decode(OP_HLT); cyc(1'b1, 1'b1, 3'b000, 1'b0, HALT, "halt");

    restart();
`ifdef CTRL_TIMEOUT_EN
    repeat (15) cyc(1'b1, 1'b0, 3'b000, 1'b0, F_WAIT, "fetch_wait");
    cyc(1'b1, 1'b0, 3'b000, 1'b0, FAULT, "fault");
    repeat (3) cyc(1'b1, 1'b1, 3'b000, 1'b0, FAULT, "fault_sticky");
`else
    repeat (20) cyc(1'b1, 1'b0, 3'b000, 1'b0, F_WAIT, "fetch_wait_long");
    retire_q.push_back(23); fetch(); decode(OP_LDI); cyc(1'b1, 1'b1, 3'b000, 1'b0, ALU_LDI, "ldi");
`endif

    repeat (2) @(negedge clk);
    check("expected_drained", exp_q.size(), 32'd0);
    check("retires_drained", retire_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
